// File: rtl/data_bus_pkg.sv
// Shared data-bus types and helpers: ramControl codes, responder FSM states,
// byte-enable, store-lane replication and load-extension functions.
package data_bus_pkg;

  typedef enum logic [2:0] {
    RC_B  = 3'b000,
    RC_H  = 3'b001,
    RC_W  = 3'b010,
    RC_BU = 3'b100,
    RC_HU = 3'b101
  } rc_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } resp_state_e;

  function automatic logic rc_legal(input logic [2:0] rc);
    case (rc)
      RC_B, RC_H, RC_W, RC_BU, RC_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic rc_misaligned(input logic [2:0] rc, input logic [1:0] lane);
    case (rc)
      RC_H, RC_HU: return lane[0];
      RC_W:        return |lane;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] rc, input logic [1:0] lane);
    case (rc)
      RC_B, RC_BU: return 4'b0001 << lane;
      RC_H, RC_HU: return 4'b0011 << lane;
      RC_W:        return 4'b1111;
      default:     return 4'b0000;
    endcase
  endfunction

  // Right-justified store data is replicated so every lane sees its slice.
  function automatic logic [31:0] store_data(input logic [2:0] rc, input logic [31:0] wdata);
    case (rc)
      RC_B, RC_BU: return {4{wdata[7:0]}};
      RC_H, RC_HU: return {2{wdata[15:0]}};
      default:     return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] rc,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (rc)
      RC_B:    return {{24{b[7]}}, b};
      RC_BU:   return {24'h0, b};
      RC_H:    return {{16{h[15]}}, h};
      RC_HU:   return {16'h0, h};
      RC_W:    return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// Data-bus signal bundle between the address decoder/core (master) and a RAM responder (slave).
// Load results return one cycle after the request; the responder never stalls the bus.
interface data_bus_responder_if;
  logic        busSel;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [2:0]  ramControl;
  logic        errClr;
  logic [31:0] busRData;
  logic        rValid;
  logic        busErr;

  modport master (
    output busSel, busWe, busAddr, busWData, ramControl, errClr,
    input  busRData, rValid, busErr
  );

  modport slave (
    input  busSel, busWe, busAddr, busWData, ramControl, errClr,
    output busRData, rValid, busErr
  );
endinterface

// File: rtl/data_ram_bytewr.sv
// Word RAM with four byte-lane write enables and a registered read port.
// Latency: read data valid the cycle after re; no backpressure, one access per cycle.
module data_ram_bytewr #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-bus RAM responder: B/H/W loads and stores, sticky error flag; DATA_BUS_ACCESS_CNT_EN adds access counters.
// Latency: load result 1 cycle after request (back-to-back allowed); stores complete at the edge; never stalls.
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic               clk,
  input  logic               reset,
  data_bus_responder_if.slave bus
`ifdef DATA_BUS_ACCESS_CNT_EN
  ,
  output logic [31:0]        loadCnt,
  output logic [31:0]        storeCnt
`endif
);

  logic [31:0]           off;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  out_of_range;
  logic                  illegal;
  logic                  load_req;
  logic                  store_ok;
  logic [31:0]           ram_rdata;
  logic [31:0]           resp_data;
  logic [31:0]           last_q;
  logic [1:0]            lane_q;
  logic [2:0]            rc_q;
  logic                  ill_q;
  resp_state_e           state_q, state_d;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the same range test.
  assign off          = bus.busAddr - BASE_ADDR;
  assign lane         = off[1:0];
  assign widx         = off[ADDR_WIDTH+1:2];
  assign out_of_range = |off[31:ADDR_WIDTH+2];
  assign illegal      = !rc_legal(bus.ramControl) || rc_misaligned(bus.ramControl, lane)
                        || out_of_range;
  assign load_req     = bus.busSel && !bus.busWe;
  assign store_ok     = bus.busSel && bus.busWe && !illegal;

  data_ram_bytewr #(.AW(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (store_ok),
    .be    (byte_en(bus.ramControl, lane)),
    .re    (load_req),
    .addr  (widx),
    .wdata (store_data(bus.ramControl, bus.busWData)),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (load_req) begin
      lane_q <= lane;
      rc_q   <= bus.ramControl;
      ill_q  <= illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    if (load_req) state_d = RESP;
      RESP:    if (load_req) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  assign resp_data = ill_q ? 32'h0 : load_ext(ram_rdata, rc_q, lane_q);

  // last_q keeps the previous result visible while no response is pending.
  always_ff @(posedge clk) begin
    if (!reset)              last_q <= 32'h0;
    else if (state_q == RESP) last_q <= resp_data;
  end

  assign bus.busRData = (state_q == RESP) ? resp_data : last_q;
  assign bus.rValid   = (state_q == RESP) && reset;

  always_ff @(posedge clk) begin
    if (!reset)                         bus.busErr <= 1'b0;
    else if (bus.busSel && illegal)     bus.busErr <= 1'b1;
    else if (bus.errClr)                bus.busErr <= 1'b0;
  end

`ifdef DATA_BUS_ACCESS_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      loadCnt  <= 32'h0;
      storeCnt <= 32'h0;
    end else begin
      if (load_req && !illegal) loadCnt  <= loadCnt + 32'd1;
      if (store_ok)             storeCnt <= storeCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed-vector bench for data_bus_responder: table of single accesses plus
// back-to-back, reset-mid-response and read-after-write sequences.
module tb_data_bus_responder;

  localparam logic [31:0] B = 32'h1000_0000;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  data_bus_responder_if bus_if ();

  data_bus_responder #(.ADDR_WIDTH(10), .BASE_ADDR(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic        we;
    logic        clr;
    logic [2:0]  rc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_rv;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic we, input logic clr, input logic [2:0] rc,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus_if.busSel     = sel;
    bus_if.busWe      = we;
    bus_if.errClr     = clr;
    bus_if.ramControl = rc;
    bus_if.busAddr    = addr;
    bus_if.busWData   = wdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // sel we clr rc addr wdata | exp_rd rv err
    vecs.push_back('{1,1,0,3'b010, B+0,     32'hDEADBEEF, 32'h00000000, 0, 0});
    vecs.push_back('{1,0,0,3'b010, B+0,     32'h0,        32'hDEADBEEF, 1, 0});
    vecs.push_back('{1,1,0,3'b000, B+3,     32'hAAAAAA80, 32'hDEADBEEF, 0, 0});
    vecs.push_back('{1,0,0,3'b010, B+0,     32'h0,        32'h80ADBEEF, 1, 0});
    vecs.push_back('{1,0,0,3'b000, B+3,     32'h0,        32'hFFFFFF80, 1, 0});
    vecs.push_back('{1,0,0,3'b100, B+3,     32'h0,        32'h00000080, 1, 0});
    vecs.push_back('{1,0,0,3'b000, B+1,     32'h0,        32'hFFFFFFBE, 1, 0});
    vecs.push_back('{1,1,0,3'b010, B+4,     32'h12345678, 32'hFFFFFFBE, 0, 0});
    vecs.push_back('{1,1,0,3'b001, B+6,     32'h55558001, 32'hFFFFFFBE, 0, 0});
    vecs.push_back('{1,0,0,3'b001, B+6,     32'h0,        32'hFFFF8001, 1, 0});
    vecs.push_back('{1,0,0,3'b101, B+6,     32'h0,        32'h00008001, 1, 0});
    vecs.push_back('{1,0,0,3'b010, B+4,     32'h0,        32'h80015678, 1, 0});
    vecs.push_back('{1,0,0,3'b001, B+4,     32'h0,        32'h00005678, 1, 0});
    vecs.push_back('{1,0,0,3'b101, B+2,     32'h0,        32'h000080AD, 1, 0});
    vecs.push_back('{1,0,0,3'b001, B+2,     32'h0,        32'hFFFF80AD, 1, 0});
    vecs.push_back('{1,0,0,3'b010, B+2,     32'h0,        32'h00000000, 1, 1});
    vecs.push_back('{1,0,0,3'b010, B+0,     32'h0,        32'h80ADBEEF, 1, 1});
    vecs.push_back('{1,1,0,3'b010, B+4096,  32'hCAFEF00D, 32'h80ADBEEF, 0, 1});
    vecs.push_back('{1,0,1,3'b010, B+0,     32'h0,        32'h80ADBEEF, 1, 0});
    vecs.push_back('{1,0,0,3'b001, B+1,     32'h0,        32'h00000000, 1, 1});
    vecs.push_back('{0,0,1,3'b010, B+0,     32'h0,        32'h00000000, 0, 0});
    vecs.push_back('{1,0,1,3'b010, B+1,     32'h0,        32'h00000000, 1, 1});
    vecs.push_back('{0,0,1,3'b010, B+0,     32'h0,        32'h00000000, 0, 0});
    vecs.push_back('{1,0,0,3'b011, B+0,     32'h0,        32'h00000000, 1, 1});
    vecs.push_back('{0,0,1,3'b010, B+0,     32'h0,        32'h00000000, 0, 0});
    vecs.push_back('{1,0,0,3'b010, B-4,     32'h0,        32'h00000000, 1, 1});
    vecs.push_back('{0,0,1,3'b010, B+0,     32'h0,        32'h00000000, 0, 0});
    vecs.push_back('{1,1,0,3'b000, B+4095,  32'h0000007F, 32'h00000000, 0, 0});
    vecs.push_back('{1,0,0,3'b000, B+4095,  32'h0,        32'h0000007F, 1, 0});
    vecs.push_back('{1,0,0,3'b100, B+4096,  32'h0,        32'h00000000, 1, 1});
    vecs.push_back('{0,0,1,3'b010, B+0,     32'h0,        32'h00000000, 0, 0});
    vecs.push_back('{1,1,0,3'b001, B+5,     32'h0000FFFF, 32'h00000000, 0, 1});
    vecs.push_back('{0,0,1,3'b010, B+0,     32'h0,        32'h00000000, 0, 0});
    vecs.push_back('{1,0,0,3'b010, B+4,     32'h0,        32'h80015678, 1, 0});
    vecs.push_back('{1,1,0,3'b110, B+0,     32'h00000000, 32'h80015678, 0, 1});
    vecs.push_back('{0,0,1,3'b010, B+0,     32'h0,        32'h80015678, 0, 0});
    vecs.push_back('{1,0,0,3'b010, B+0,     32'h0,        32'h80ADBEEF, 1, 0});

    reset = 1'b0;
    idle();
    step();
    step();
    check("reset_rdata", 0, bus_if.busRData, 32'h0);
    check("reset_rvalid", 0, {31'h0, bus_if.rValid}, 32'h0);
    check("reset_err", 0, {31'h0, bus_if.busErr}, 32'h0);
    reset = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sel, vecs[i].we, vecs[i].clr, vecs[i].rc, vecs[i].addr, vecs[i].wdata);
      step();
      check("vec_rdata", i, bus_if.busRData, vecs[i].exp_rd);
      check("vec_rvalid", i, {31'h0, bus_if.rValid}, {31'h0, vecs[i].exp_rv});
      check("vec_err", i, {31'h0, bus_if.busErr}, {31'h0, vecs[i].exp_err});
      idle();
      step();
      check("vec_pulse_end", i, {31'h0, bus_if.rValid}, 32'h0);
    end

    // Back-to-back loads: one result per cycle, then hold.
    drive(1, 0, 0, 3'b010, B+0, 0);
    step();
    check("b2b_rdata", 0, bus_if.busRData, 32'h80ADBEEF);
    check("b2b_rvalid", 0, {31'h0, bus_if.rValid}, 32'h1);
    drive(1, 0, 0, 3'b010, B+4, 0);
    step();
    check("b2b_rdata", 1, bus_if.busRData, 32'h80015678);
    check("b2b_rvalid", 1, {31'h0, bus_if.rValid}, 32'h1);
    drive(1, 0, 0, 3'b000, B+3, 0);
    step();
    check("b2b_rdata", 2, bus_if.busRData, 32'hFFFFFF80);
    check("b2b_rvalid", 2, {31'h0, bus_if.rValid}, 32'h1);
    idle();
    step();
    check("b2b_hold_rdata", 3, bus_if.busRData, 32'hFFFFFF80);
    check("b2b_rvalid", 3, {31'h0, bus_if.rValid}, 32'h0);

    // Leave busErr set, then reset during the second of a load burst.
    drive(1, 0, 0, 3'b010, B+2, 0);
    step();
    idle();
    step();
    check("pre_reset_err", 0, {31'h0, bus_if.busErr}, 32'h1);
    drive(1, 0, 0, 3'b010, B+0, 0);
    step();
    check("rst_seq_rvalid", 0, {31'h0, bus_if.rValid}, 32'h1);
    drive(1, 0, 0, 3'b010, B+4, 0);
    step();
    check("rst_seq_rdata", 1, bus_if.busRData, 32'h80015678);
    drive(1, 0, 0, 3'b010, B+0, 0);
    reset = 1'b0;
    #1;
    check("rst_cycle_rvalid", 1, {31'h0, bus_if.rValid}, 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_rvalid", 2, {31'h0, bus_if.rValid}, 32'h0);
    check("post_rst_rdata", 2, bus_if.busRData, 32'h0);
    check("post_rst_err", 2, {31'h0, bus_if.busErr}, 32'h0);
    reset = 1'b1;
    idle();
    step();
    drive(1, 0, 0, 3'b010, B+4, 0);
    step();
    check("persist_rdata", 3, bus_if.busRData, 32'h80015678);
    check("persist_rvalid", 3, {31'h0, bus_if.rValid}, 32'h1);
    idle();
    step();

    // Load in the cycle right after a store to the same word.
    drive(1, 1, 0, 3'b010, B+8, 32'h0BADCAFE);
    step();
    drive(1, 0, 0, 3'b010, B+8, 0);
    step();
    check("raw_rdata", 0, bus_if.busRData, 32'h0BADCAFE);
    check("raw_rvalid", 0, {31'h0, bus_if.rValid}, 32'h1);
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Responder (target) side of the core's data bus: a word-organised data RAM that services byte, halfword and word loads and stores.
- Access width and signedness come from the 3-bit ramControl (funct3) code.
- Sits behind the address decoder; selected by busSel. Write is synchronous; read data is registered with 1-cycle latency, matching the multicycle core's MEM→WB timing.
- Detects misaligned and out-of-range accesses and reports them through a sticky error flag.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h1000_0000, byte address of word 0.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- busSel  input  1  decoder select; access valid only when high
- busWe  input  1  1 = store, 0 = load
- busAddr  input  32  byte address
- busWData  input  32  store data, right-justified (byte in [7:0], halfword in [15:0])
- ramControl  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- busRData  output  32  registered, extended load data
- rValid  output  1  1-cycle pulse when busRData holds a new load result
- busErr  output  1  sticky error flag
- errClr  input  1  clears busErr

Behaviour:
- Reset (reset==0 at a clk edge):
  - busRData=0, rValid=0, busErr=0, FSM→IDLE.
  - RAM contents are not cleared.
- Offset: off = busAddr - BASE_ADDR. Word index = off[ADDR_WIDTH+1:2]; lane = off[1:0].
- Range check: out-of-range when off >= 4*2**ADDR_WIDTH (unsigned; addresses below BASE_ADDR wrap to large values, so they are also out of range).
- Alignment check: misaligned when H/HU with lane[0]=1, or W with lane!=0.
- Illegal access: illegal ramControl, misaligned, or out-of-range.
  - The access is ignored: no RAM write; load returns 0 with rValid still pulsed.
  - busErr is set.
- Store, at the clk edge with busSel&busWe legal:
  - B: byte enable = 1<<lane; data = {4{wdata[7:0]}}.
  - H: enable = 2'b11<<lane; data = {2{wdata[15:0]}}.
  - W: enable = 4'hF.
  - Only the enabled bytes change; no response pulse is generated.
- Load FSM:
  - IDLE: on busSel & !busWe, capture lane, ramControl and the illegal flag, read the word → RESP.
  - RESP: drive busRData = extended result, rValid=1 for exactly this cycle.
    - If another load is requested in the same cycle: capture it and stay in RESP (back-to-back, one result per cycle).
    - Otherwise → IDLE.
- Extension:
  - B: sign-extend byte[lane].
  - BU: zero-extend byte[lane].
  - H: sign-extend halfword[lane[1]].
  - HU: zero-extend halfword[lane[1]].
  - W: full word.
- busRData holds its last value when rValid=0.
- Read-after-write: a load in the cycle after a store to the same word returns the new data. Read-during-write is the only hazard; same-cycle load and store are impossible because busWe selects one.
- busErr:
  - Set on any illegal selected access.
  - errClr clears it.
  - If an error and errClr occur in the same cycle, set wins.
- busSel=0: no write, no read capture; the FSM returns to IDLE after any pending RESP.
- Reset mid-RESP: rValid is forced to 0 in the reset cycle and the result is dropped.

Optional Feature:
- Macro: DATA_BUS_ACCESS_CNT_EN.
- When defined:
  - Adds outputs loadCnt[31:0] and storeCnt[31:0].
  - Each counter increments on every legal selected load/store respectively.
  - Counters wrap at 2**32, reset to 0, and are unaffected by errClr.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package data_bus_pkg:
  - enum of ramControl codes (RC_B, RC_H, RC_W, RC_BU, RC_HU).
  - FSM state enum (IDLE, RESP).
  - Function for byte-enable generation.
  - Function for load extension, shared with the core's datapath.
- One sub-module, data_ram_bytewr: a 4-byte-lane write-enabled RAM with registered read.

Test Plan:
- Store word: SW 32'hDEADBEEF at BASE+0, then LW BASE+0 → the next cycle gives busRData=32'hDEADBEEF and rValid=1 for 1 cycle.
- Byte lanes and sign extension:
  - SB 8'h80 at BASE+3 over the word above, then LW → 32'h80ADBEEF.
  - LB BASE+3 → 32'hFFFFFF80; LBU BASE+3 → 32'h00000080.
- Halfword: SH 16'h8001 at BASE+6, then LH BASE+6 → 32'hFFFF8001 and LHU → 32'h00008001.
- Misaligned and out-of-range:
  - LW at BASE+2 → busRData=0, rValid=1, busErr=1; RAM unchanged.
  - SW at BASE+4*2**ADDR_WIDTH → no write, busErr=1.
  - errClr for 1 cycle → busErr=0.
- Back-to-back and reset:
  - 3 consecutive loads → 3 consecutive rValid pulses with the correct data.
  - Assert reset during the second → rValid=0 and busRData=0 in the next cycle; RAM data persists on a later read.
